// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : run_ctrl
// Purpose  : Start/Ack responder for the job handshake. Holds the core at its
//            initial state while Start is high, runs it once Start falls, and
//            acknowledges on halt or on cycle-budget exhaustion.
// Revision : 1.0 - initial release
// ============================================================================
module run_ctrl #(
  parameter int unsigned MAX_CYCLES = 100000,
  parameter int unsigned CW         = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  output logic          Ack,
  output logic          CoreInit,
  output logic          CoreRun,
  output logic          TimedOut,
  output logic [CW-1:0] CycleCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } stateT;

  localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_CYCLES);

  stateT         state;
  logic [CW-1:0] countInc;

  assign countInc = CycleCount + CW'(1);

  // Core controls are pure decodes of the state register, so they glitch-free
  // follow state and respond to Reset without waiting for a clock edge.
  assign CoreInit = (state == IDLE) || (state == ARMED);
  assign CoreRun  = (state == RUN);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      Ack        <= 1'b0;
      TimedOut   <= 1'b0;
      CycleCount <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            state      <= ARMED;
            TimedOut   <= 1'b0;
            CycleCount <= '0;
          end
        end

        ARMED: begin
          TimedOut   <= 1'b0;
          CycleCount <= '0;
          if (!Start) begin
            state <= RUN;
          end
        end

        RUN: begin
          // Abort beats halt, and halt beats the budget check on the same edge.
          if (Start) begin
            state      <= ARMED;
            TimedOut   <= 1'b0;
            CycleCount <= '0;
          end else if (Halt) begin
            state      <= DONE;
            Ack        <= 1'b1;
            TimedOut   <= 1'b0;
            CycleCount <= countInc;
          end else if (CycleCount == LAST_COUNT) begin
            state      <= DONE;
            Ack        <= 1'b1;
            TimedOut   <= 1'b1;
            CycleCount <= FULL_COUNT;
          end else begin
            CycleCount <= countInc;
          end
        end

        DONE: begin
          if (Start) begin
            state      <= ARMED;
            Ack        <= 1'b0;
            TimedOut   <= 1'b0;
            CycleCount <= '0;
          end
        end

        default: begin
          state <= IDLE;
          Ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_ctrl
// Purpose  : Scoreboard bench for run_ctrl; expected job results are queued at
//            stimulus time and checked by a monitor on every Ack rise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_ctrl;

  localparam int MAX = 64;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic          ack;
  logic          coreInit;
  logic          coreRun;
  logic          timedOut;
  logic [CW-1:0] cycleCount;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          to;
  } expT;

  expT sb[$];
  int  checks = 0;
  int  fails  = 0;
  logic ackPrev = 1'b0;

  run_ctrl #(.MAX_CYCLES(MAX), .CW(CW)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .Start      (start),
    .Halt       (halt),
    .Ack        (ack),
    .CoreInit   (coreInit),
    .CoreRun    (coreRun),
    .TimedOut   (timedOut),
    .CycleCount (cycleCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every Ack rise must match the oldest queued job result.
  always @(negedge clk) begin
    if (ack === 1'b1 && ackPrev !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_ack: got Ack=1 count=%0d, expected no Ack", cycleCount);
      end else begin
        expT e;
        e = sb.pop_front();
        check("sb_count", cycleCount, e.cnt);
        check("sb_timedout", {31'd0, timedOut}, {31'd0, e.to});
      end
    end
    ackPrev <= ack;
  end

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle Start pulse from IDLE or DONE; leaves Start high in ARMED.
  task automatic arm(input string name);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check({name, "_armed_init"}, {31'd0, coreInit}, 32'd1);
    check({name, "_armed_count"}, cycleCount, 32'd0);
    check({name, "_armed_ack"}, {31'd0, ack}, 32'd0);
  endtask

  // haltAt = 0 means never assert Halt.
  task automatic runJob(input string name, input int haltAt, input int expCnt, input bit expTo);
    int  runCycles;
    bit  gotAck;
    expT e;
    runCycles = 0;
    gotAck    = 1'b0;
    e.cnt     = CW'(expCnt);
    e.to      = expTo;
    sb.push_back(e);
    start = 1'b0;
    for (int c = 1; c <= MAX + 5; c++) begin
      @(negedge clk);
      if (coreRun) runCycles++;
      if (ack) begin
        gotAck = 1'b1;
        break;
      end
      halt = (c == haltAt);
    end
    halt = 1'b0;
    if (!gotAck) begin
      checks++;
      fails++;
      $display("FAIL %s_ack_timeout: got no Ack, expected Ack within %0d cycles", name, MAX + 5);
    end
    check({name, "_run_cycles"}, runCycles, expCnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_init", {31'd0, coreInit}, 32'd1);
    check("rst_run", {31'd0, coreRun}, 32'd0);
    check("rst_count", cycleCount, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Normal job: halt on RUN cycle 25
    arm("norm");
    runJob("norm", 25, 25, 1'b0);
    repeat (3) @(negedge clk);
    check("norm_ack_hold", {31'd0, ack}, 32'd1);
    check("norm_count_hold", cycleCount, 32'd25);

    // Timeout, then halt exactly on the last budget cycle
    arm("tmo");
    runJob("tmo", 0, MAX, 1'b1);
    check("tmo_flag", {31'd0, timedOut}, 32'd1);
    arm("tmoh");
    runJob("tmoh", MAX, MAX, 1'b0);
    check("tmoh_flag", {31'd0, timedOut}, 32'd0);

    // Back-to-back: Start while Ack high drops Ack and clears count
    arm("b2b1");
    runJob("b2b1", 10, 10, 1'b0);
    arm("b2b2");
    runJob("b2b2", 7, 7, 1'b0);

    // Ten jobs with reset between each
    for (int i = 0; i < 10; i++) begin
      doReset();
      check("batch_rst_count", cycleCount, 32'd0);
      arm("batch");
      runJob("batch", i + 2, i + 2, 1'b0);
    end

    // Abort on RUN cycle 5 with Halt also high
    doReset();
    arm("abort");
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    halt  = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("abort_ack", {31'd0, ack}, 32'd0);
    check("abort_count", cycleCount, 32'd0);
    check("abort_init", {31'd0, coreInit}, 32'd1);
    check("abort_run", {31'd0, coreRun}, 32'd0);
    runJob("abort_after", 6, 6, 1'b0);

    // Asynchronous reset mid-RUN at CycleCount = 40
    arm("areset");
    start = 1'b0;
    for (int c = 0; c < MAX && cycleCount != 40; c++) @(negedge clk);
    check("areset_reach40", cycleCount, 32'd40);
    #2;
    reset = 1'b1;
    #1;
    check("areset_ack", {31'd0, ack}, 32'd0);
    check("areset_run", {31'd0, coreRun}, 32'd0);
    check("areset_count", cycleCount, 32'd0);
    check("areset_to", {31'd0, timedOut}, 32'd0);
    check("areset_init", {31'd0, coreInit}, 32'd1);
    @(negedge clk);
    start = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    check("areset_armed_init", {31'd0, coreInit}, 32'd1);
    runJob("areset_after", 3, 3, 1'b0);

    // Spurious Halt in IDLE, ARMED and DONE
    doReset();
    halt = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_idle_run", {31'd0, coreRun}, 32'd0);
    check("spur_idle_count", cycleCount, 32'd0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_armed_init", {31'd0, coreInit}, 32'd1);
    check("spur_armed_count", cycleCount, 32'd0);
    halt = 1'b0;
    runJob("spur", 9, 9, 1'b0);
    halt = 1'b1;
    repeat (4) @(negedge clk);
    halt = 1'b0;
    check("spur_done_ack", {31'd0, ack}, 32'd1);
    check("spur_done_count", cycleCount, 32'd9);
    check("spur_done_run", {31'd0, coreRun}, 32'd0);

    @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
